instr_decode_stage: RTL and testbench

- Pipeline stage between instruction fetch and the operand path of the 16-bit multi-register accumulator datapath.
- Latches fetched 16-bit words over a valid/ready handshake.
- Assembles two-word extended-immediate instructions.
- Presents decoded fields (opcode, register selects, raw 4-bit immediate, full 16-bit immediate) in one registered bundle. The 4-bit immediate output feeds the downstream 4-to-16 zero-extender directly.

---
 rtl/instr_decode_pkg.sv | 32 +++
 rtl/instr_decode_stage.sv | 109 ++++++++++
 tb/tb_instr_decode_stage.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/instr_decode_pkg.sv
// Shared constants and types for the instruction decode stage.
// Opcode map, field positions, FSM encoding and bundle width.
package instr_decode_pkg;

  localparam logic [3:0] OPC_EXT  = 4'hF;
  localparam logic [3:0] OPC_RSV0 = 4'hC;
  localparam logic [3:0] OPC_RSV1 = 4'hD;
  localparam logic [3:0] OPC_RSV2 = 4'hE;

  localparam int OPC_MSB  = 15;
  localparam int OPC_LSB  = 12;
  localparam int RA_LSB   = 8;
  localparam int RB_LSB   = 4;
  localparam int IMM4_LSB = 0;

  localparam int REG_W = 2;

  // opcode, ra, rb, imm4, imm16, is_ext, illegal
  localparam int BUNDLE_W = 4 + 2 * REG_W + 4 + 16 + 2;

  typedef enum logic {
    S_FIRST = 1'b0,
    S_EXT   = 1'b1
  } state_t;

  function automatic logic is_reserved(
    input logic [3:0] opc
  );
    return opc inside {OPC_RSV0, OPC_RSV1, OPC_RSV2};
  endfunction

endpackage

// File: rtl/instr_decode_stage.sv
// Decode stage: handshake latch plus two-word immediate assembly.
// ILLEGAL_OP_TRAP_EN enables out_illegal and a sticky illegal flag.
module instr_decode_stage
  import instr_decode_pkg::*;
#(
  parameter logic [3:0] EXT_OPCODE    = OPC_EXT,
  parameter int         NUM_REGS_LOG2 = REG_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [15:0]              in_word,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [3:0]               out_opcode,
  output logic [NUM_REGS_LOG2-1:0] out_ra,
  output logic [NUM_REGS_LOG2-1:0] out_rb,
  output logic [3:0]               out_imm4,
  output logic [15:0]              out_imm16,
  output logic                     out_is_ext,
  output logic                     out_illegal
);

  localparam int FW = 8 + 2 * NUM_REGS_LOG2;

  state_t              state_q;
  logic [FW-1:0]       hold_q;
  logic [FW-1:0]       fields_in;
  logic [BUNDLE_W-1:0] bundle_q;
  logic [BUNDLE_W-1:0] bundle_d;
  logic [BUNDLE_W-1:0] single_b;
  logic [BUNDLE_W-1:0] ext_b;
  logic                acc_in;
  logic                acc_out;
  logic                first_ext;
  logic                load;
  logic                ill_first;
  logic                ill_hold;

  assign in_ready  = !flush && (!out_valid || out_ready);
  assign acc_in    = in_valid && in_ready;
  assign acc_out   = out_valid && out_ready;
  assign first_ext = in_word[OPC_MSB:OPC_LSB] == EXT_OPCODE;

  assign fields_in = {
    in_word[OPC_MSB:OPC_LSB],
    in_word[RA_LSB +: NUM_REGS_LOG2],
    in_word[RB_LSB +: NUM_REGS_LOG2],
    in_word[IMM4_LSB +: 4]
  };

`ifdef ILLEGAL_OP_TRAP_EN
  assign ill_first = is_reserved(fields_in[FW-1 -: 4]);
  assign ill_hold  = is_reserved(hold_q[FW-1 -: 4]);
`else
  assign ill_first = 1'b0;
  assign ill_hold  = 1'b0;
`endif

  assign single_b = {fields_in, 16'h0000, 1'b0, ill_first};
  assign ext_b    = {hold_q, in_word, 1'b1, ill_hold};

  // The word after an extension opcode is data, never an opcode.
  assign load     = acc_in && (state_q == S_EXT || !first_ext);
  assign bundle_d = (state_q == S_EXT) ? ext_b : single_b;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FIRST;
      out_valid <= 1'b0;
      bundle_q  <= '0;
      hold_q    <= '0;
    end else if (flush) begin
      state_q   <= S_FIRST;
      out_valid <= 1'b0;
    end else if (load) begin
      state_q   <= S_FIRST;
      out_valid <= 1'b1;
      bundle_q  <= bundle_d;
    end else if (acc_in) begin
      // Accepting implies any prior bundle drains this cycle.
      state_q   <= S_EXT;
      out_valid <= 1'b0;
      hold_q    <= fields_in;
    end else if (acc_out) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ILLEGAL_OP_TRAP_EN
  logic illegal_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_seen <= 1'b0;
    end else if (!flush && load && bundle_d[0]) begin
      illegal_seen <= 1'b1;
    end
  end
`endif

  assign {
    out_opcode, out_ra, out_rb, out_imm4,
    out_imm16, out_is_ext, out_illegal
  } = bundle_q;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Randomized bench for instr_decode_stage against a word-level model.
// Directed literal checks pin the model's field extraction.
module tb_instr_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_word;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_opcode;
  logic [1:0]  out_ra;
  logic [1:0]  out_rb;
  logic [3:0]  out_imm4;
  logic [15:0] out_imm16;
  logic        out_is_ext;
  logic        out_illegal;

  instr_decode_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_word     (in_word),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_opcode  (out_opcode),
    .out_ra      (out_ra),
    .out_rb      (out_rb),
    .out_imm4    (out_imm4),
    .out_imm16   (out_imm16),
    .out_is_ext  (out_is_ext),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic reserved(input logic [3:0] o);
`ifdef ILLEGAL_OP_TRAP_EN
    return (o >= 4'hC) && (o <= 4'hE);
`else
    return 1'b0;
`endif
  endfunction

  // Model: the visible bundle is "first word" + "imm16" + "ext flag".
  logic        m_valid;
  logic        m_pending;
  logic [15:0] m_first;
  logic [15:0] m_word;
  logic [15:0] m_imm16;
  logic        m_ext;

  always @(posedge clk or posedge rst) begin : model
    logic rdy;
    if (rst) begin
      m_valid   = 1'b0;
      m_pending = 1'b0;
      m_first   = 16'h0;
      m_word    = 16'h0;
      m_imm16   = 16'h0;
      m_ext     = 1'b0;
    end else begin
      rdy = !flush && (!m_valid || out_ready);
      if (flush) begin
        m_valid   = 1'b0;
        m_pending = 1'b0;
      end else if (in_valid && rdy) begin
        if (m_pending) begin
          m_word    = m_first;
          m_imm16   = in_word;
          m_ext     = 1'b1;
          m_valid   = 1'b1;
          m_pending = 1'b0;
        end else if (in_word[15:12] == 4'hF) begin
          m_first   = in_word;
          m_pending = 1'b1;
          m_valid   = 1'b0;
        end else begin
          m_word  = in_word;
          m_imm16 = 16'h0;
          m_ext   = 1'b0;
          m_valid = 1'b1;
        end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("in_ready", in_ready,
          !flush && (!m_valid || out_ready));
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("opcode", out_opcode, m_word[15:12]);
        chk("ra", out_ra, m_word[9:8]);
        chk("rb", out_rb, m_word[5:4]);
        chk("imm4", out_imm4, m_word[3:0]);
        chk("imm16", out_imm16, m_imm16);
        chk("is_ext", out_is_ext, m_ext);
        chk("illegal", out_illegal,
            reserved(m_word[15:12]));
      end
    end
  end

  task automatic cyc(
    input logic        v,
    input logic [15:0] w,
    input logic        r,
    input logic        f
  );
    in_valid  = v;
    in_word   = w;
    out_ready = r;
    flush     = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] w;
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_word   = 16'h0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_opcode", out_opcode, 0);
    chk("rst_imm16", out_imm16, 0);
    chk("rst_ext", out_is_ext, 0);
    chk("rst_illegal", out_illegal, 0);

    cyc(1, 16'h3A57, 1, 0);
    chk("d1_valid", out_valid, 1);
    chk("d1_opcode", out_opcode, 3);
    chk("d1_ra", out_ra, 2);
    chk("d1_rb", out_rb, 1);
    chk("d1_imm4", out_imm4, 7);
    chk("d1_imm16", out_imm16, 0);
    chk("d1_ext", out_is_ext, 0);

    cyc(1, 16'hF1B9, 1, 0);
    chk("d2_gap", out_valid, 0);
    cyc(1, 16'h1234, 1, 0);
    chk("d2_valid", out_valid, 1);
    chk("d2_ext", out_is_ext, 1);
    chk("d2_opcode", out_opcode, 4'hF);
    chk("d2_ra", out_ra, 1);
    chk("d2_rb", out_rb, 3);
    chk("d2_imm4", out_imm4, 9);
    chk("d2_imm16", out_imm16, 16'h1234);

    for (int i = 0; i < 3; i++) begin
      cyc(1, 16'h5123, 0, 0);
      chk("stall_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_imm16", out_imm16, 16'h1234);
    end
    cyc(1, 16'h5123, 1, 0);
    chk("unstall_valid", out_valid, 1);
    chk("unstall_opcode", out_opcode, 5);
    chk("unstall_imm16", out_imm16, 0);

    for (int i = 0; i < 8; i++) begin
      cyc(1, {4'(i), 12'(i * 273)}, 1, 0);
      chk("stream_valid", out_valid, 1);
      chk("stream_opcode", out_opcode, i);
    end

    cyc(1, 16'hF000, 1, 0);
    chk("fl_pre", out_valid, 0);
    cyc(0, 16'h0, 1, 1);
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 0);
    cyc(1, 16'h2003, 1, 0);
    chk("fl_opcode", out_opcode, 2);
    chk("fl_imm4", out_imm4, 3);
    chk("fl_ext", out_is_ext, 0);

    cyc(1, 16'hC000, 1, 0);
    chk("ill_valid", out_valid, 1);
`ifdef ILLEGAL_OP_TRAP_EN
    chk("ill_flag", out_illegal, 1);
`else
    chk("ill_flag", out_illegal, 0);
`endif

    cyc(1, 16'hF000, 1, 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    cyc(1, 16'h4321, 1, 0);
    chk("arst_opcode", out_opcode, 4);
    chk("arst_ext", out_is_ext, 0);
    chk("arst_ra", out_ra, 3);
    chk("arst_rb", out_rb, 2);

    for (int i = 0; i < 2000; i++) begin
      w = 16'($urandom);
      if ($urandom_range(3) == 0) w[15:12] = 4'hF;
      cyc($urandom_range(3) != 0, w,
          $urandom_range(3) != 0,
          $urandom_range(19) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
